// File: rtl/ball_physics.sv
// Bouncing ball motion engine: fixed-point position and speed with wall, ceiling
// and floor rebounds under gravity, plus launch/pop lifecycle control.
module ball_physics #(
  parameter int FRAC_BITS       = 6,
  parameter int COORD_W         = 11,
  parameter int SPEED_W         = 16,
  parameter int FRAME_W         = 640,
  parameter int FRAME_H         = 480,
  parameter int BALL_SIZE       = 32,
  parameter int INITIAL_X_SPEED = 100,
  parameter int LAUNCH_Y_SPEED  = -128,
  parameter int BOUNCE_Y_SPEED  = 384,
  parameter int G               = 4,
  parameter int MAX_Y_SPEED     = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               launch,
  input  logic [COORD_W-1:0] launchX,
  input  logic [COORD_W-1:0] launchY,
  input  logic               dirLeft,
  input  logic               pop,
  output logic [COORD_W-1:0] topLeftX,
  output logic [COORD_W-1:0] topLeftY,
  output logic               active,
  output logic               popped,
  output logic               floorBounce
);

  localparam int POS_W  = COORD_W + FRAC_BITS + 2;
  localparam int CALC_W = POS_W + SPEED_W;
  localparam logic signed [CALC_W-1:0] XMAX = CALC_W'((FRAME_W - BALL_SIZE) << FRAC_BITS);
  localparam logic signed [CALC_W-1:0] YMAX = CALC_W'((FRAME_H - BALL_SIZE) << FRAC_BITS);

  typedef enum logic [1:0] {IDLE, MOVING, POPPED} stateT;

  stateT                      state, stateNext;
  logic signed [POS_W-1:0]    posX, posY, posXNext, posYNext;
  logic signed [SPEED_W-1:0]  xSpeed, ySpeed, xSpeedNext, ySpeedNext;
  logic                       poppedNext, floorBounceNext;
  logic signed [CALC_W-1:0]   nx, ny;
  logic signed [SPEED_W-1:0]  absX, absY;
  logic signed [SPEED_W:0]    ySum;

  // Next-state and next-datapath logic; pop wins over a coincident frame tick.
  always_comb begin
    stateNext       = state;
    posXNext        = posX;
    posYNext        = posY;
    xSpeedNext      = xSpeed;
    ySpeedNext      = ySpeed;
    poppedNext      = 1'b0;
    floorBounceNext = 1'b0;
    nx   = CALC_W'(posX) + CALC_W'(xSpeed);
    ny   = CALC_W'(posY) + CALC_W'(ySpeed);
    absX = xSpeed[SPEED_W-1] ? -xSpeed : xSpeed;
    absY = ySpeed[SPEED_W-1] ? -ySpeed : ySpeed;
    ySum = (SPEED_W+1)'(ySpeed) + (SPEED_W+1)'(G);

    case (state)
      IDLE: begin
        if (launch) begin
          posXNext   = $signed({2'b00, launchX, {FRAC_BITS{1'b0}}});
          posYNext   = $signed({2'b00, launchY, {FRAC_BITS{1'b0}}});
          xSpeedNext = dirLeft ? -SPEED_W'(INITIAL_X_SPEED) : SPEED_W'(INITIAL_X_SPEED);
          ySpeedNext = SPEED_W'(LAUNCH_Y_SPEED);
          stateNext  = MOVING;
        end
      end
      MOVING: begin
        if (pop) begin
          poppedNext = 1'b1;
          stateNext  = POPPED;
        end else if (startOfFrame) begin
          if (nx < 0) begin
            posXNext   = '0;
            xSpeedNext = absX;
          end else if (nx > XMAX) begin
            posXNext   = POS_W'(XMAX);
            xSpeedNext = -absX;
          end else begin
            posXNext = nx[POS_W-1:0];
          end
          // Floor rebound speed is fixed so the bounce height never decays or grows.
          if (ny >= YMAX) begin
            posYNext        = POS_W'(YMAX);
            ySpeedNext      = SPEED_W'(-BOUNCE_Y_SPEED);
            floorBounceNext = 1'b1;
          end else if (ny < 0) begin
            posYNext   = '0;
            ySpeedNext = absY;
          end else begin
            posYNext   = ny[POS_W-1:0];
            ySpeedNext = (ySum > (SPEED_W+1)'(MAX_Y_SPEED)) ? SPEED_W'(MAX_Y_SPEED)
                                                            : ySum[SPEED_W-1:0];
          end
        end
      end
      POPPED: begin
        if (startOfFrame) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      posX        <= '0;
      posY        <= '0;
      xSpeed      <= '0;
      ySpeed      <= '0;
      popped      <= 1'b0;
      floorBounce <= 1'b0;
    end else begin
      state       <= stateNext;
      posX        <= posXNext;
      posY        <= posYNext;
      xSpeed      <= xSpeedNext;
      ySpeed      <= ySpeedNext;
      popped      <= poppedNext;
      floorBounce <= floorBounceNext;
    end
  end

  assign topLeftX = COORD_W'(posX >>> FRAC_BITS);
  assign topLeftY = COORD_W'(posY >>> FRAC_BITS);
  assign active   = (state != IDLE);

endmodule

// File: tb/tb_ball_physics.sv
// Scoreboard bench for ball_physics: a default instance and one with a
// positive launch speed for the floor case; expectations are hand-derived.
module tb_ball_physics;

  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    startOfFrame = '0, launch = '0, dirLeft = '0, pop = '0;
  logic [CW-1:0] launchX [2];
  logic [CW-1:0] launchY [2];
  logic [CW-1:0] topLeftX [2];
  logic [CW-1:0] topLeftY [2];
  logic [1:0]    active, popped, floorBounce;

  typedef struct {
    int    dut;
    int    due;
    int    x;
    int    y;
    bit    act;
    bit    pop;
    bit    fb;
    string name;
  } expT;

  expT sb[$];
  expT mon;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ball_physics dutA (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame[0]), .launch(launch[0]),
    .launchX(launchX[0]), .launchY(launchY[0]), .dirLeft(dirLeft[0]), .pop(pop[0]),
    .topLeftX(topLeftX[0]), .topLeftY(topLeftY[0]), .active(active[0]),
    .popped(popped[0]), .floorBounce(floorBounce[0])
  );

  ball_physics #(.LAUNCH_Y_SPEED(64)) dutB (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame[1]), .launch(launch[1]),
    .launchX(launchX[1]), .launchY(launchY[1]), .dirLeft(dirLeft[1]), .pop(pop[1]),
    .topLeftX(topLeftX[1]), .topLeftY(topLeftY[1]), .active(active[1]),
    .popped(popped[1]), .floorBounce(floorBounce[1])
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: compares every expectation whose cycle has arrived, away from the rising edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon = sb.pop_front();
      checkOutput({mon.name, ".x"},   16'(topLeftX[mon.dut]),    16'(mon.x));
      checkOutput({mon.name, ".y"},   16'(topLeftY[mon.dut]),    16'(mon.y));
      checkOutput({mon.name, ".act"}, 16'(active[mon.dut]),      16'(mon.act));
      checkOutput({mon.name, ".pop"}, 16'(popped[mon.dut]),      16'(mon.pop));
      checkOutput({mon.name, ".fb"},  16'(floorBounce[mon.dut]), 16'(mon.fb));
    end
  end

  task automatic applyStimulus(input int d, input bit rst, input bit lau, input bit sof,
                               input bit pp, input bit dl, input int lx, input int ly,
                               input int ex, input int ey, input bit eAct, input bit ePop,
                               input bit eFb, input string name);
    expT e;
    @(negedge clk);
    reset        = rst;
    launch       = '0;
    startOfFrame = '0;
    pop          = '0;
    dirLeft      = '0;
    launchX[0] = '0; launchY[0] = '0; launchX[1] = '0; launchY[1] = '0;
    launch[d]       = lau;
    startOfFrame[d] = sof;
    pop[d]          = pp;
    dirLeft[d]      = dl;
    launchX[d]      = CW'(lx);
    launchY[d]      = CW'(ly);
    e = '{dut: d, due: cyc + 1, x: ex, y: ey, act: eAct, pop: ePop, fb: eFb, name: name};
    sb.push_back(e);
    if (rst) begin
      e.dut  = 1 - d;
      e.name = {name, "_other"};
      sb.push_back(e);
    end
  endtask

  initial begin
    //            d rst lau sof pop dl  lx   ly    ex   ey act pop fb
    applyStimulus(0, 1, 0, 0, 0, 0,   0,   0,    0,   0, 0, 0, 0, "reset");
    applyStimulus(0, 0, 0, 1, 0, 0,   0,   0,    0,   0, 0, 0, 0, "idleHold");
    applyStimulus(0, 0, 1, 0, 0, 0, 100, 200,  100, 200, 1, 0, 0, "launch");
    applyStimulus(0, 0, 0, 1, 0, 0,   0,   0,  101, 198, 1, 0, 0, "frame1");
    applyStimulus(0, 0, 0, 0, 0, 0,   0,   0,  101, 198, 1, 0, 0, "noFrameHold");
    applyStimulus(0, 0, 0, 1, 0, 0,   0,   0,  103, 196, 1, 0, 0, "frame2");
    applyStimulus(0, 0, 1, 0, 0, 1,   5,   5,  103, 196, 1, 0, 0, "launchIgnored");
    applyStimulus(0, 0, 0, 1, 1, 0,   0,   0,  103, 196, 1, 1, 0, "popWins");
    applyStimulus(0, 0, 0, 0, 1, 0,   0,   0,  103, 196, 1, 0, 0, "popIgnored");
    applyStimulus(0, 0, 0, 1, 0, 0,   0,   0,  103, 196, 0, 0, 0, "backToIdle");
    applyStimulus(0, 0, 1, 0, 0, 0, 607, 100,  607, 100, 1, 0, 0, "launchRight");
    applyStimulus(0, 0, 0, 1, 0, 0,   0,   0,  608,  98, 1, 0, 0, "rightWall");
    applyStimulus(0, 0, 0, 1, 0, 0,   0,   0,  606,  96, 1, 0, 0, "rightRebound");
    applyStimulus(0, 0, 0, 0, 1, 0,   0,   0,  606,  96, 1, 1, 0, "pop2");
    applyStimulus(0, 0, 0, 1, 0, 0,   0,   0,  606,  96, 0, 0, 0, "idle2");
    applyStimulus(0, 0, 1, 0, 0, 1,   0,   0,    0,   0, 1, 0, 0, "launchCorner");
    applyStimulus(0, 0, 0, 1, 0, 0,   0,   0,    0,   0, 1, 0, 0, "leftCeiling");
    applyStimulus(0, 0, 0, 1, 0, 0,   0,   0,    1,   2, 1, 0, 0, "cornerRebound");
    applyStimulus(1, 0, 1, 0, 0, 0,  10, 447,   10, 447, 1, 0, 0, "launchFloor");
    applyStimulus(1, 0, 0, 1, 0, 0,   0,   0,   11, 448, 1, 0, 1, "floorHit");
    applyStimulus(1, 0, 0, 0, 0, 0,   0,   0,   11, 448, 1, 0, 0, "floorPulseEnd");
    applyStimulus(1, 0, 0, 1, 0, 0,   0,   0,   13, 442, 1, 0, 0, "floorRebound");
    applyStimulus(0, 1, 1, 1, 1, 0,  50,  50,    0,   0, 0, 0, 0, "midReset");
    applyStimulus(0, 0, 1, 0, 0, 0, 100, 200,  100, 200, 1, 0, 0, "relaunch");
    applyStimulus(0, 0, 0, 0, 0, 0,   0,   0,  100, 200, 1, 0, 0, "settle");
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
